data_mem_responder: RTL and testbench
=====================================

# data_mem_responder

Data-memory responder for the RISC-V core: the memory-side end of the core's load/store interface. Accepts one load or store request at a time through a valid/ready handshake, and decodes the access size and sign from the instruction's func3. It applies byte-lane masking on stores and alignment plus sign/zero extension on loads, and detects misaligned, out-of-range or illegal accesses. It returns a single-cycle response after a programmable number of wait states.

## Interface
- DEPTH, 256: number of 32-bit words in the internal array; byte address range is 0 .. 4*DEPTH-1.
- WAIT_CYCLES, 0: extra wait states on loads; legal range 0..15.
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept; equals (state == IDLE).
- req_we  input  1  1 = store, 0 = load.
- req_func3  input  3  RISC-V load/store func3.
- req_addr  input  32  byte address (ALU result).
- req_wdata  input  32  store data (rs2); only low bytes used for SB/SH.
- resp_valid  output  1  one-cycle response strobe.
- resp_rdata  output  32  formatted load data; 0 for stores and errors.
- resp_err  output  1  qualified by resp_valid; access faulted.

## Operation
- FSM states are IDLE, WAIT and RESP. Reset enters IDLE.
- IDLE: a request is accepted on a rising edge when req_valid=1.
  - If the access is faulted, go to RESP with err=1. The array is not written.
  - For a store, write the array at the accepting edge, then go to RESP.
  - For a load with WAIT_CYCLES=0, go to RESP and capture the formatted read data at the same edge.
  - For a load with WAIT_CYCLES>0, go to WAIT and load the counter with WAIT_CYCLES-1.
- WAIT: the counter decrements each cycle. When it reaches 0, the next edge reads the array, registers the formatted data and enters RESP.
- RESP: resp_valid=1 for exactly one cycle. The next state is unconditionally IDLE. There is no response back-pressure; the core stalls on req_ready/resp_valid.
- Word index is req_addr[log2(DEPTH)+1:2]. Byte offset is req_addr[1:0].
- Load func3 encodings:
  - 000 LB: sign-extend the selected byte.
  - 001 LH: sign-extend the selected halfword.
  - 010 LW.
  - 100 LBU: zero-extend the selected byte.
  - 101 LHU: zero-extend the selected halfword.
- Store func3 encodings:
  - 000 SB: byte enable = 1 << addr[1:0], with req_wdata[7:0] replicated to every lane.
  - 001 SH: byte enable = 0011 or 1100, selected by addr[1].
  - 010 SW: byte enable = 1111.
- An access is faulted if any of the following holds:
  - illegal func3 (load 011/110/111; store anything other than 000/001/010);
  - halfword access with addr[0]=1;
  - word access with addr[1:0]≠00;
  - req_addr ≥ 4*DEPTH, with the upper bits compared in full 32-bit width.
- Array contents are not reset. They are preserved across rst_n.

## Timing
- Reset values: resp_valid=0, resp_rdata=0, resp_err=0, and FSM in IDLE. Consequently req_ready=1 while in reset and immediately after.
- Stores, faults, and loads with WAIT_CYCLES=0: accept at edge E, resp_valid high in cycle E+1, req_ready high again from cycle E+2.
- Loads in general: resp_valid is high in cycle E+1+WAIT_CYCLES.
- req_ready is low from the accepting edge until the response cycle ends. req_valid during that window is ignored, not queued.
- resp_rdata and resp_err are held at their last values outside resp_valid. The bench checks them only when resp_valid=1.
- Reset asserted in WAIT or RESP returns the FSM to IDLE asynchronously and drops resp_valid; the pending load returns no response. A store accepted before reset stays written.
- The highest address 4*DEPTH-4 is legal for LW/SW. 4*DEPTH faults. Addresses wrap neither in the index nor in the counter.

## Test plan
- Word round trip, WAIT_CYCLES=0: SW 0xDEADBEEF at 0x10, then LW 0x10 → resp_rdata=0xDEADBEEF, err=0; each response arrives one cycle after acceptance.
- Sub-word stores and loads: SW 0x00000000 at 0x20, SB 0x85 at 0x23, SH 0x1234 at 0x20 → LW=0x85001234, LB 0x23=0xFFFFFF85, LBU 0x23=0x00000085, LH 0x22=0xFFFF8500, LHU 0x20=0x00001234.
- Faults:
  - LH at 0x21 → err=1;
  - SW at 0x22 → err=1, with a later LW 0x20 showing the word unchanged;
  - load func3=011 → err=1;
  - LW at 4*DEPTH → err=1, rdata=0.
- Wait states, WAIT_CYCLES=3: LW accepted at edge E → resp_valid exactly in cycle E+4, req_ready low in cycles E+1..E+4, and req_valid pulses during that window produce no extra response.
- Reset mid-load (WAIT_CYCLES=3): assert rst_n=0 in cycle E+2 → resp_valid never rises and req_ready=1. After release, LW of the previously stored location returns the stored value.
- Back-to-back traffic: req_valid held high with 8 alternating SW/LW requests to addresses 0 and 4*DEPTH-4 → one response per request, with the correct data and order.

Source files
------------

// File: rtl/data_mem_responder.sv
// data_mem_responder: memory-side end of the core's load/store port with byte-lane
// stores, aligned/extended loads, fault detection and programmable load wait states.
module data_mem_responder #(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_func3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem [DEPTH];
  logic        idle, fault, mem_we;
  logic [AW+1:0] a;
  logic [2:0]  f3;
  logic [31:0] word, sh, fmt, wd;
  logic [3:0]  be;
  always_comb begin
    idle  = state_q == S_IDLE;
    a     = idle ? req_addr[AW+1:0] : addr_q;
    f3    = idle ? req_func3 : f3_q;
    fault = (req_we ? (req_func3[2] | (req_func3[1:0] == 2'b11))
                    : ((req_func3[1:0] == 2'b11) | (req_func3 == 3'b110)))
          | ((req_func3[1:0] == 2'b01) & req_addr[0])
          | ((req_func3[1:0] == 2'b10) & (|req_addr[1:0]))
          | (req_addr >= 32'(4 * DEPTH));
    mem_we = idle & req_valid & req_we & ~fault & rst_n;
    be    = req_func3[1:0] == 2'b00 ? 4'b0001 << req_addr[1:0] :
            req_func3[1:0] == 2'b01 ? (req_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wd    = req_func3[1:0] == 2'b00 ? {4{req_wdata[7:0]}} :
            req_func3[1:0] == 2'b01 ? {2{req_wdata[15:0]}} : req_wdata;
    word  = mem[a[AW+1:2]];
    sh    = word >> {a[1:0], 3'b000};
    fmt   = f3[1:0] == 2'b00 ? {{24{~f3[2] & sh[7]}}, sh[7:0]} :
            f3[1:0] == 2'b01 ? {{16{~f3[2] & sh[15]}}, sh[15:0]} : sh;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      f3_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  // Array is deliberately outside the reset domain so contents survive rst_n.
  always_ff @(posedge clk)
    if (mem_we)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[req_addr[AW+1:2]][8*i +: 8] <= wd[8*i +: 8];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE:
        if (req_valid) begin
          addr_d  = req_addr[AW+1:0];
          f3_d    = req_func3;
          err_d   = fault;
          rdata_d = '0;
          state_d = S_RESP;
          if (!fault && !req_we) begin
            if (WAIT_CYCLES == 0) rdata_d = fmt;
            else begin
              state_d = S_WAIT;
              cnt_d   = 4'(WAIT_CYCLES - 1);
            end
          end
        end
      S_WAIT:
        if (cnt_q == 4'd0) begin
          rdata_d = fmt;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else cnt_d = cnt_q - 4'd1;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_comb begin
    req_ready  = state_q == S_IDLE;
    resp_valid = state_q == S_RESP;
    resp_rdata = rdata_q;
    resp_err   = err_q;
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of a zero-wait and a three-wait-state responder.
module tb_data_mem_responder;
  logic        clk = 0;
  logic        rst0 = 0, rst3 = 0;
  logic        v0 = 0, v3 = 0;
  logic        req_we = 0;
  logic [2:0]  req_func3 = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        rdy0, rdy3, rv0, rv3, er0, er3;
  logic [31:0] rd0, rd3;
  int          passed = 0, total = 0;
  always #5 clk = ~clk;
  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst0), .req_valid(v0), .req_ready(rdy0), .req_we(req_we),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv0), .resp_rdata(rd0), .resp_err(er0));
  data_mem_responder #(.DEPTH(256), .WAIT_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst3), .req_valid(v3), .req_ready(rdy3), .req_we(req_we),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rv3), .resp_rdata(rd3), .resp_err(er3));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic xfer(input bit d, input bit we, input logic [2:0] f3, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input bit exp_err,
                      input int exp_lat, input string tag);
    int lat;
    @(negedge clk);
    req_we = we; req_func3 = f3; req_addr = a; req_wdata = wd;
    if (d) v3 = 1; else v0 = 1;
    @(posedge clk); #1;
    v0 = 0; v3 = 0;
    lat = 1;
    while (!(d ? rv3 : rv0) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " lat"}, lat, exp_lat);
    chk({tag, " rdata"}, d ? rd3 : rd0, exp_rd);
    chk({tag, " err"}, d ? er3 : er0, {31'b0, exp_err});
    @(posedge clk);
  endtask
  initial begin
    #2;
    chk("rst ready", {31'b0, rdy0}, 1);
    chk("rst valid", {31'b0, rv0}, 0);
    chk("rst rdata", rd0, 0);
    chk("rst err", {31'b0, er0}, 0);
    @(negedge clk); @(negedge clk);
    rst0 = 1; rst3 = 1;
    xfer(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 0, 1, "sw10");
    xfer(0, 0, 3'b010, 32'h10, 0, 32'hDEADBEEF, 0, 1, "lw10");
    xfer(0, 1, 3'b010, 32'h20, 32'h0, 0, 0, 1, "sw20");
    xfer(0, 1, 3'b000, 32'h23, 32'hAAAAAA85, 0, 0, 1, "sb23");
    xfer(0, 1, 3'b001, 32'h20, 32'hFFFF1234, 0, 0, 1, "sh20");
    xfer(0, 0, 3'b010, 32'h20, 0, 32'h85001234, 0, 1, "lw20");
    xfer(0, 0, 3'b000, 32'h23, 0, 32'hFFFFFF85, 0, 1, "lb23");
    xfer(0, 0, 3'b100, 32'h23, 0, 32'h00000085, 0, 1, "lbu23");
    xfer(0, 0, 3'b001, 32'h22, 0, 32'hFFFF8500, 0, 1, "lh22");
    xfer(0, 0, 3'b101, 32'h20, 0, 32'h00001234, 0, 1, "lhu20");
    xfer(0, 0, 3'b001, 32'h21, 0, 0, 1, 1, "lh21");
    xfer(0, 1, 3'b010, 32'h22, 32'h11111111, 0, 1, 1, "sw22");
    xfer(0, 0, 3'b010, 32'h20, 0, 32'h85001234, 0, 1, "lw20b");
    xfer(0, 0, 3'b011, 32'h20, 0, 0, 1, 1, "ld011");
    xfer(0, 0, 3'b010, 32'd1024, 0, 0, 1, 1, "lw1024");
    xfer(0, 1, 3'b011, 32'h20, 32'h0, 0, 1, 1, "st011");
    @(negedge clk);
    v0 = 1;
    for (int i = 0; i < 8; i++) begin
      req_we = (i % 2) == 0;
      req_func3 = 3'b010;
      req_addr = (i % 4) < 2 ? 32'd0 : 32'd1020;
      req_wdata = 32'hA5000000 + i;
      chk("b2b ready", {31'b0, rdy0}, 1);
      @(negedge clk);
      chk("b2b valid", {31'b0, rv0}, 1);
      chk("b2b rdata", rd0, (i % 2) == 0 ? 32'h0 : 32'hA5000000 + i - 1);
      chk("b2b err", {31'b0, er0}, 0);
      @(negedge clk);
      chk("b2b gap", {31'b0, rv0}, 0);
    end
    v0 = 0;
    xfer(1, 1, 3'b010, 32'h40, 32'hCAFEF00D, 0, 0, 1, "w3 sw40");
    @(negedge clk);
    req_we = 0; req_func3 = 3'b010; req_addr = 32'h40;
    v3 = 1;
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      #1;
      if (k == 1) req_addr = 32'h44;
      if (k == 4) begin
        chk("w3 rdata", rd3, 32'hCAFEF00D);
        chk("w3 err", {31'b0, er3}, 0);
      end
      chk($sformatf("w3 valid c%0d", k), {31'b0, rv3}, {31'b0, k == 4});
      chk($sformatf("w3 ready c%0d", k), {31'b0, rdy3}, {31'b0, k >= 5});
      if (k == 3) v3 = 0;
      @(posedge clk);
    end
    @(negedge clk);
    req_addr = 32'h40;
    v3 = 1;
    @(posedge clk); #1;
    v3 = 0;
    @(posedge clk); #1;
    rst3 = 0;
    #1;
    chk("mid rst ready", {31'b0, rdy3}, 1);
    chk("mid rst valid", {31'b0, rv3}, 0);
    chk("mid rst rdata", rd3, 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 2) rst3 = 1;
      chk("mid rst no resp", {31'b0, rv3}, 0);
    end
    xfer(1, 0, 3'b010, 32'h40, 0, 32'hCAFEF00D, 0, 4, "w3 lw40 post");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
